// File: rtl/core_muldiv.sv
// Iterative RV32M-style multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, sign fixed up on the way out.
module core_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_num1u,
    input  logic [XLEN-1:0] i_num2u,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_res
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   mag2;
    logic [2*XLEN-1:0] acc;

    // Operand decode for an incoming start
    logic            is_div, sgn1, sgn2, neg1, neg2, start_neg, div_zero, div_ovf;
    logic [XLEN-1:0] abs1, abs2, special_res;

    always_comb begin
        is_div      = i_funct3[2];
        sgn1        = is_div ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11);
        sgn2        = is_div ? ~i_funct3[0] : ~i_funct3[1];
        neg1        = sgn1 & i_num1u[XLEN-1];
        neg2        = sgn2 & i_num2u[XLEN-1];
        abs1        = neg1 ? -i_num1u : i_num1u;
        abs2        = neg2 ? -i_num2u : i_num2u;
        // Remainder follows the dividend sign; everything else follows sign1^sign2
        start_neg   = (is_div & i_funct3[1]) ? neg1 : (neg1 ^ neg2);
        div_zero    = is_div & (i_num2u == '0);
        div_ovf     = is_div & ~i_funct3[0] & (i_num1u == MOST_NEG) & (i_num2u == '1);
        special_res = div_zero ? (i_funct3[1] ? i_num1u : '1)
                               : (i_funct3[1] ? '0 : i_num1u);
    end

    // One iteration: acc holds {partial, multiplier} or {remainder, dividend/quotient}
    logic [XLEN:0]     sum, rem_sh, rem_new;
    logic              ge, unused_rem_top;
    logic [2*XLEN-1:0] step, prod_fix;
    logic [XLEN-1:0]   quo, rem, final_res;

    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag2} : '0);
        rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge       = rem_sh >= {1'b0, mag2};
        rem_new  = ge ? (rem_sh - {1'b0, mag2}) : rem_sh;
        step     = op[2] ? {rem_new[XLEN-1:0], acc[XLEN-2:0], ge}
                         : {sum, acc[XLEN-1:1]};
        prod_fix = neg ? -step : step;
        quo      = neg ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem      = neg ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        if (op[2])
            final_res = op[1] ? rem : quo;
        else if (op[1:0] == 2'b00)
            final_res = prod_fix[XLEN-1:0];
        else
            final_res = prod_fix[2*XLEN-1:XLEN];
    end
    assign unused_rem_top = rem_new[XLEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            neg   <= 1'b0;
            mag2  <= '0;
            acc   <= '0;
            o_res <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start && !i_flush) begin
                        op   <= i_funct3;
                        neg  <= start_neg;
                        mag2 <= abs2;
                        acc  <= {{XLEN{1'b0}}, abs1};
                        cnt  <= '0;
                        if (div_zero || div_ovf) begin
                            o_res <= special_res;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (i_flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= step;
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(XLEN-1)) begin
                            o_res <= final_res;
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy = (state != IDLE);
    assign o_done = (state == DONE);
endmodule

// File: tb/tb_core_muldiv.sv
// Scoreboard bench for core_muldiv: stimulus pushes expected results and
// completion cycles, a negedge monitor pops and compares on every o_done.
module tb_core_muldiv;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst, i_start, i_flush;
    logic [2:0]  i_funct3;
    logic [31:0] i_num1u, i_num2u;
    logic        o_busy, o_done;
    logic [31:0] o_res;

    core_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_flush(i_flush),
        .i_funct3(i_funct3), .i_num1u(i_num1u), .i_num2u(i_num2u),
        .o_busy(o_busy), .o_done(o_done), .o_res(o_res)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          at;
        logic [2:0]  f;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end
    endtask

    // Reference: plain integer arithmetic following the RV M-extension rules
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sbv, ua, ubv;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ubv = longint'({32'd0, b});
        ia  = int'(a);
        ib  = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        model = '0;
        case (f)
            3'd0: model = a * b;
            3'd1: begin p = sa * sbv; model = p[63:32]; end
            3'd2: begin p = sa * ubv; model = p[63:32]; end
            3'd3: begin p = ua * ubv; model = p[63:32]; end
            3'd4: model = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: model = (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (o_done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got o_done=1 res=%h want no pulse", o_res);
            end else begin
                mon_e = sb.pop_front();
                $display("txn f=%0d res=%h want=%h cyc=%0d want_cyc=%0d", mon_e.f, o_res, mon_e.res, cyc, mon_e.at);
                check("result", o_res, mon_e.res);
                check("latency", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200 && o_busy !== 1'b0; i++) @(negedge clk);
        check_bit("idle_timeout", o_busy, 1'b0);
    endtask

    // Present one op for a single edge; optionally expect a result and wait it out
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input bit push, input bit wait_end);
        exp_t e;
        bit   sp;
        @(negedge clk);
        i_start = 1'b1; i_funct3 = f; i_num1u = a; i_num2u = b;
        sp = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        e.res = want; e.f = f; e.at = cyc + 1 + (sp ? 0 : XLEN);
        if (push) sb.push_back(e);
        @(negedge clk);
        i_start = 1'b0; i_funct3 = 3'($urandom); i_num1u = $urandom; i_num2u = $urandom;
        check_bit("busy_after_start", o_busy, 1'b1);
        if (sp) begin
            @(negedge clk);
            check_bit("busy_special_end", o_busy, 1'b0);
        end
        if (wait_end) begin
            wait_idle();
            if (push) last_res = want;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'd0;
            1: pick = 32'h8000_0000;
            2: pick = 32'hFFFF_FFFF;
            3: pick = 32'($urandom_range(0, 20));
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        rst = 1'b1; i_start = 1'b0; i_flush = 1'b0; i_funct3 = '0; i_num1u = '0; i_num2u = '0;
        #12;
        check_bit("reset_busy", o_busy, 1'b0);
        check_bit("reset_done", o_done, 1'b0);
        check("reset_res", o_res, 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 1);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 1);
        issue(3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1, 1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, 1);
        issue(3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1, 1);
        issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1);
        issue(3'd7, 32'd5, 32'd0, 32'd5, 1, 1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1);

        // Flush a MUL while the counter reads 10
        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0, 0);
        repeat (10) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        check_bit("flush_busy", o_busy, 1'b0);
        check("flush_res_kept", o_res, last_res);
        issue(3'd5, 32'd100, 32'd7, 32'd14, 1, 1);

        // Asynchronous reset in the middle of CALC
        issue(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'd0, 0, 0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_bit("async_rst_busy", o_busy, 1'b0);
        check("async_rst_res", o_res, 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        last_res = '0;
        repeat (40) @(negedge clk);
        check_bit("post_rst_busy", o_busy, 1'b0);

        // Start pulses during CALC must be ignored
        issue(3'd4, 32'hFFFF_FF00, 32'd9, model(3'd4, 32'hFFFF_FF00, 32'd9), 1, 0);
        for (int k = 0; k < 3; k++) begin
            repeat (4) @(negedge clk);
            i_start = 1'b1; i_funct3 = 3'd0; i_num1u = $urandom; i_num2u = $urandom;
            @(negedge clk);
            i_start = 1'b0;
        end
        wait_idle();
        last_res = model(3'd4, 32'hFFFF_FF00, 32'd9);
        repeat (2) @(negedge clk);
        check_bit("no_queued_start", o_busy, 1'b0);

        // Flush has priority over start in IDLE
        @(negedge clk);
        i_start = 1'b1; i_flush = 1'b1; i_funct3 = 3'd0; i_num1u = 32'd3; i_num2u = 32'd3;
        @(negedge clk);
        i_start = 1'b0; i_flush = 1'b0;
        check_bit("flush_beats_start", o_busy, 1'b0);
        check("flush_beats_start_res", o_res, last_res);

        for (int n = 0; n < 40; n++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            issue(f, a, b, model(f, a, b), 1, 1);
        end

        repeat (3) @(negedge clk);
        check("pending_results", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
